// File: rtl/key_event_if.sv
// Event stream from key_event_ctrl to the game logic: show-ahead head entry plus pop strobe.
interface key_event_if #(
    parameter int unsigned IDX_W = 3
) ();
    logic             ev_valid;
    logic             ev_ready;
    logic [IDX_W-1:0] ev_key;
    logic [1:0]       ev_type;

    modport master (output ev_valid, output ev_key, output ev_type, input ev_ready);
    modport slave  (input ev_valid, input ev_key, input ev_type, output ev_ready);
endinterface

// File: rtl/key_event_ctrl.sv
// Key-map and event block: matches decoder scan codes against a table, produces held/press/
// release/auto-repeat outputs and queues every event in a small show-ahead FIFO.
module key_event_ctrl #(
    parameter int unsigned           NUM_KEYS     = 7,
    parameter logic [9*NUM_KEYS-1:0] KEY_CODES    = {9'h05A, 9'h075, 9'h029, 9'h02B,
                                                     9'h023, 9'h01B, 9'h01C},
    parameter int unsigned           REPEAT_DELAY = 5000000,
    parameter int unsigned           REPEAT_RATE  = 1000000,
    parameter int unsigned           FIFO_DEPTH   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [511:0]        key_down,
    input  logic [8:0]          last_change,
    input  logic                key_valid,
    input  logic                repeat_en,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_repeat,
    key_event_if.master         ev,
    output logic                ev_overflow,
    input  logic                ovf_clr
);
    localparam int unsigned IDX_W  = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int unsigned CntMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam logic [PtrW:0] FifoFull = (PtrW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StDelay, StRate} rep_st_e;

    logic                hit, down, press_ev, rel_ev, rep_fire;
    logic [IDX_W-1:0]    idx;
    logic [NUM_KEYS-1:0] held_d, held_q, press_d, press_q, rel_d, rel_q, rep_d, rep_q;
    rep_st_e             st_d, st_q;
    logic [CntW-1:0]     cnt_d, cnt_q;
    logic [IDX_W-1:0]    tgt_d, tgt_q;

    logic                push, pop, wr_en, ovf_d, ovf_q;
    logic [IDX_W-1:0]    push_key;
    logic [1:0]          push_type;
    logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]       fcnt_d, fcnt_q;
    logic [IDX_W-1:0]    mem_key  [FIFO_DEPTH];
    logic [1:0]          mem_type [FIFO_DEPTH];

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
            if (last_change == KEY_CODES[9*i +: 9]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

    assign down     = key_down[last_change];
    assign press_ev = key_valid & hit & down & ~held_q[idx];
    assign rel_ev   = key_valid & hit & ~down & held_q[idx];

    always_comb begin
        held_d  = held_q;
        press_d = '0;
        rel_d   = '0;
        if (press_ev) begin
            held_d[idx]  = 1'b1;
            press_d[idx] = 1'b1;
        end
        if (rel_ev) begin
            held_d[idx] = 1'b0;
            rel_d[idx]  = 1'b1;
        end
    end

    always_comb begin
        st_d     = st_q;
        cnt_d    = cnt_q;
        tgt_d    = tgt_q;
        rep_fire = 1'b0;
        if (press_ev) begin
            st_d  = StDelay;
            cnt_d = CntW'(REPEAT_DELAY);
            tgt_d = idx;
        end else if (!repeat_en || (rel_ev && idx == tgt_q)) begin
            st_d = StIdle;
        end else if (st_q != StIdle) begin
            if (cnt_q == CntW'(1)) begin
                // A non-target release owns the FIFO slot this cycle; hold at 1 and retry.
                if (!rel_ev) begin
                    rep_fire = 1'b1;
                    cnt_d    = CntW'(REPEAT_RATE);
                    st_d     = StRate;
                end
            end else begin
                cnt_d = cnt_q - CntW'(1);
            end
        end
        rep_d = rep_fire ? (NUM_KEYS'(1) << tgt_q) : '0;
    end

    assign push      = press_ev | rel_ev | rep_fire;
    assign push_key  = rep_fire ? tgt_q : idx;
    assign push_type = press_ev ? 2'b01 : (rel_ev ? 2'b10 : 2'b11);
    assign pop       = (fcnt_q != '0) & ev.ev_ready;
    assign wr_en     = push & ((fcnt_q != FifoFull) | pop);
    assign ovf_d     = ovf_clr ? 1'b0 : (ovf_q | (push & ~wr_en));

    always_comb begin
        fcnt_d = fcnt_q;
        if (wr_en && !pop) begin
            fcnt_d = fcnt_q + 1'b1;
        end else if (!wr_en && pop) begin
            fcnt_d = fcnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_q   <= '0;
            press_q  <= '0;
            rel_q    <= '0;
            rep_q    <= '0;
            st_q     <= StIdle;
            cnt_q    <= '0;
            tgt_q    <= '0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_key[i]  <= '0;
                mem_type[i] <= '0;
            end
        end else begin
            held_q  <= held_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            rep_q   <= rep_d;
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            ovf_q   <= ovf_d;
            fcnt_q  <= fcnt_d;
            if (wr_en) begin
                mem_key[wr_ptr_q]  <= push_key;
                mem_type[wr_ptr_q] <= push_type;
                wr_ptr_q           <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    assign key_held    = held_q;
    assign key_press   = press_q;
    assign key_release = rel_q;
    assign key_repeat  = rep_q;
    assign ev_overflow = ovf_q;
    assign ev.ev_valid = (fcnt_q != '0);
    assign ev.ev_key   = mem_key[rd_ptr_q];
    assign ev.ev_type  = mem_type[rd_ptr_q];
endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl with short repeat timing and a 4-entry event queue.
module tb_key_event_ctrl;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [511:0] kd = '0;
    logic [8:0]   last_change = '0;
    logic         key_valid = 1'b0;
    logic         repeat_en = 1'b0;
    logic         ovf_clr = 1'b0;
    logic [6:0]   key_held, key_press, key_release, key_repeat;
    logic         ev_overflow;
    int           n_checks = 0;
    int           n_fail = 0;

    key_event_if #(.IDX_W(3)) ev_if ();

    key_event_ctrl #(
        .NUM_KEYS    (7),
        .REPEAT_DELAY(10),
        .REPEAT_RATE (4),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_down   (kd),
        .last_change(last_change),
        .key_valid  (key_valid),
        .repeat_en  (repeat_en),
        .key_held   (key_held),
        .key_press  (key_press),
        .key_release(key_release),
        .key_repeat (key_repeat),
        .ev         (ev_if),
        .ev_overflow(ev_overflow),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    logic [8:0] codes [7];
    initial begin
        codes[0] = 9'h01C; codes[1] = 9'h01B; codes[2] = 9'h023; codes[3] = 9'h02B;
        codes[4] = 9'h029; codes[5] = 9'h075; codes[6] = 9'h05A;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [8:0] code, input logic dn);
        kd[code]    = dn;
        last_change = code;
        key_valid   = 1'b1;
        step();
        key_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        kd = '0;
        key_valid = 1'b0;
        repeat_en = 1'b0;
        ovf_clr = 1'b0;
        ev_if.ev_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({key_held, key_press, key_release, key_repeat} !== 28'h0) begin
            n_fail++;
            $display("FAIL reset_keys: got %h want 0", {key_held, key_press, key_release, key_repeat});
        end
        n_checks++;
        if ({ev_if.ev_valid, ev_overflow} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ev: got %b want 00", {ev_if.ev_valid, ev_overflow});
        end
    endtask

    task automatic test_press();
        send(9'h01C, 1'b1);
        n_checks++;
        if (key_press !== 7'h01 || key_held !== 7'h01) begin
            n_fail++;
            $display("FAIL press_pulse: got press=%h held=%h want 01/01", key_press, key_held);
        end
        n_checks++;
        if (ev_if.ev_valid !== 1'b1 || ev_if.ev_key !== 3'd0 || ev_if.ev_type !== 2'b01) begin
            n_fail++;
            $display("FAIL press_event: got v=%b k=%0d t=%b want 1/0/01",
                     ev_if.ev_valid, ev_if.ev_key, ev_if.ev_type);
        end
        step();
        n_checks++;
        if (key_press !== 7'h00 || key_held !== 7'h01) begin
            n_fail++;
            $display("FAIL press_one_cycle: got press=%h held=%h want 00/01", key_press, key_held);
        end
        ev_if.ev_ready = 1'b1;
        step();
        ev_if.ev_ready = 1'b0;
        n_checks++;
        if (ev_if.ev_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL press_pop: got ev_valid=%b want 0", ev_if.ev_valid);
        end
    endtask

    task automatic test_typematic();
        int np = 0;
        int nr = 0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(9'h01C, 1'b1);
            np += int'(key_press[0]);
        end
        send(9'h01C, 1'b0);
        nr += int'(key_release[0]);
        step();
        nr += int'(key_release[0]);
        n_checks++;
        if (np != 1 || nr != 1 || key_held !== 7'h00) begin
            n_fail++;
            $display("FAIL typematic_pulses: got press=%0d rel=%0d held=%h want 1/1/00",
                     np, nr, key_held);
        end
        n_checks++;
        if (ev_if.ev_valid !== 1'b1 || ev_if.ev_type !== 2'b01) begin
            n_fail++;
            $display("FAIL typematic_ev0: got v=%b t=%b want 1/01", ev_if.ev_valid, ev_if.ev_type);
        end
        ev_if.ev_ready = 1'b1;
        step();
        n_checks++;
        if (ev_if.ev_valid !== 1'b1 || ev_if.ev_type !== 2'b10 || ev_if.ev_key !== 3'd0) begin
            n_fail++;
            $display("FAIL typematic_ev1: got v=%b k=%0d t=%b want 1/0/10",
                     ev_if.ev_valid, ev_if.ev_key, ev_if.ev_type);
        end
        step();
        ev_if.ev_ready = 1'b0;
        n_checks++;
        if (ev_if.ev_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL typematic_empty: got ev_valid=%b want 0", ev_if.ev_valid);
        end
    endtask

    task automatic test_repeat();
        logic [6:0] exp_rep;
        do_reset();
        repeat_en = 1'b1;
        ev_if.ev_ready = 1'b1;
        send(9'h05A, 1'b1);
        n_checks++;
        if (key_press !== 7'h40 || ev_if.ev_type !== 2'b01 || ev_if.ev_key !== 3'd6) begin
            n_fail++;
            $display("FAIL repeat_press: got press=%h t=%b k=%0d want 40/01/6",
                     key_press, ev_if.ev_type, ev_if.ev_key);
        end
        for (int t = 1; t <= 20; t++) begin
            step();
            exp_rep = (t == 10 || t == 14 || t == 18) ? 7'h40 : 7'h00;
            n_checks++;
            if (key_repeat !== exp_rep) begin
                n_fail++;
                $display("FAIL repeat_t%0d: got %h want %h", t, key_repeat, exp_rep);
            end
            if (exp_rep != 7'h00) begin
                n_checks++;
                if (ev_if.ev_valid !== 1'b1 || ev_if.ev_type !== 2'b11 || ev_if.ev_key !== 3'd6) begin
                    n_fail++;
                    $display("FAIL repeat_ev_t%0d: got v=%b t=%b k=%0d want 1/11/6",
                             t, ev_if.ev_valid, ev_if.ev_type, ev_if.ev_key);
                end
            end
        end
        send(9'h05A, 1'b0);
        n_checks++;
        if (key_release !== 7'h40 || key_repeat !== 7'h00 || ev_if.ev_type !== 2'b10) begin
            n_fail++;
            $display("FAIL repeat_release: got rel=%h rep=%h t=%b want 40/00/10",
                     key_release, key_repeat, ev_if.ev_type);
        end
        for (int t = 0; t < 8; t++) begin
            step();
            n_checks++;
            if (key_repeat !== 7'h00) begin
                n_fail++;
                $display("FAIL repeat_stopped: got %h want 00", key_repeat);
            end
        end
        ev_if.ev_ready = 1'b0;
        n_checks++;
        if (ev_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL repeat_no_ovf: got %b want 0", ev_overflow);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 4; i++) send(codes[i], 1'b1);
        n_checks++;
        if (ev_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_before: got %b want 0", ev_overflow);
        end
        send(codes[4], 1'b1);
        n_checks++;
        if (ev_overflow !== 1'b1 || key_press !== 7'h10 || key_held !== 7'h1F) begin
            n_fail++;
            $display("FAIL ovf_set: got ovf=%b press=%h held=%h want 1/10/1f",
                     ev_overflow, key_press, key_held);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (ev_if.ev_valid !== 1'b1 || ev_if.ev_key !== 3'(i) || ev_if.ev_type !== 2'b01) begin
                n_fail++;
                $display("FAIL ovf_pop%0d: got v=%b k=%0d t=%b want 1/%0d/01",
                         i, ev_if.ev_valid, ev_if.ev_key, ev_if.ev_type, i);
            end
            ev_if.ev_ready = 1'b1;
            step();
            ev_if.ev_ready = 1'b0;
        end
        n_checks++;
        if (ev_if.ev_valid !== 1'b0 || ev_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: got v=%b ovf=%b want 0/1", ev_if.ev_valid, ev_overflow);
        end
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        n_checks++;
        if (ev_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: got %b want 0", ev_overflow);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 4; i++) send(codes[i], 1'b1);
        ev_if.ev_ready = 1'b1;
        send(codes[4], 1'b1);
        ev_if.ev_ready = 1'b0;
        n_checks++;
        if (ev_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL fullpp_ovf: got %b want 0", ev_overflow);
        end
        for (int i = 1; i <= 4; i++) begin
            n_checks++;
            if (ev_if.ev_valid !== 1'b1 || ev_if.ev_key !== 3'(i)) begin
                n_fail++;
                $display("FAIL fullpp_pop%0d: got v=%b k=%0d want 1/%0d",
                         i, ev_if.ev_valid, ev_if.ev_key, i);
            end
            ev_if.ev_ready = 1'b1;
            step();
            ev_if.ev_ready = 1'b0;
        end
        n_checks++;
        if (ev_if.ev_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fullpp_empty: got ev_valid=%b want 0", ev_if.ev_valid);
        end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        repeat_en = 1'b1;
        send(9'h05A, 1'b1);
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({key_held, key_press, key_release, key_repeat} !== 28'h0 ||
            ev_if.ev_valid !== 1'b0 || ev_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_async: got keys=%h v=%b ovf=%b want 0/0/0",
                     {key_held, key_press, key_release, key_repeat}, ev_if.ev_valid, ev_overflow);
        end
        repeat (2) step();
        rst_n = 1'b1;
        for (int t = 0; t < 20; t++) begin
            step();
            n_checks++;
            if ({key_held, key_release, key_repeat} !== 21'h0 || ev_if.ev_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_quiet_t%0d: got keys=%h v=%b want 0/0",
                         t, {key_held, key_release, key_repeat}, ev_if.ev_valid);
            end
        end
    endtask

    initial begin
        ev_if.ev_ready = 1'b0;
        test_reset();
        test_press();
        test_typematic();
        test_repeat();
        test_overflow();
        test_full_push_pop();
        test_reset_mid_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
